// File: rtl/layer_offset_scheduler.sv
// Per-replica layer offset registers with shadowed writes and an atomic vblank commit.
// Pending positions are applied as-is; every other replica scrolls by its velocity with wrap.
module layer_offset_scheduler #(
  parameter int unsigned HWIDTH   = 12,
  parameter int unsigned VWIDTH   = 12,
  parameter int unsigned HSIZE    = 640,
  parameter int unsigned VSIZE    = 480,
  parameter int unsigned REPLICAS = 1,
  parameter int unsigned IDXW     = 4,
  parameter int unsigned VELW     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [HWIDTH-1:0] hdata,
  input  logic [VWIDTH-1:0] vdata,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [IDXW-1:0]   wr_idx,
  input  logic              wr_sel,
  input  logic [HWIDTH-1:0] wr_h,
  input  logic [VWIDTH-1:0] wr_v,
  output logic [HWIDTH-1:0] hoffset [REPLICAS],
  output logic [VWIDTH-1:0] voffset [REPLICAS],
  output logic              frame_done
);

  localparam int unsigned SW = ((HWIDTH > VWIDTH) ? HWIDTH : VWIDTH) + 2;
  localparam int unsigned CW = (REPLICAS > 1) ? $clog2(REPLICAS) : 1;
  localparam logic signed [SW-1:0] HSZ = SW'(HSIZE);
  localparam logic signed [SW-1:0] VSZ = SW'(VSIZE);

  typedef enum logic [1:0] {ACCEPT, COMMIT, DONE} state_t;

  state_t                 state;
  logic [CW-1:0]          cnt;
  logic [HWIDTH-1:0]      shadow_h [REPLICAS];
  logic [VWIDTH-1:0]      shadow_v [REPLICAS];
  logic signed [VELW-1:0] vel_h    [REPLICAS];
  logic signed [VELW-1:0] vel_v    [REPLICAS];
  logic [REPLICAS-1:0]    pending;
  logic                   trig_q;
  logic                   trig_c;
  logic                   rise_c;

  // Commit fires once on entry to the first line of vertical blank.
  assign trig_c = (hdata == '0) && (vdata == VWIDTH'(VSIZE));
  assign rise_c = trig_c & ~trig_q;

  // Single-wrap modulo: velocity magnitude is below the wrap size.
  function automatic logic signed [SW-1:0] wrap(input logic signed [SW-1:0] s,
                                                 input logic signed [SW-1:0] size);
    logic signed [SW-1:0] r;
    r = s;
    if (s[SW-1])        r = s + size;
    else if (s >= size) r = s - size;
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ACCEPT;
      cnt        <= '0;
      wr_ready   <= 1'b1;
      frame_done <= 1'b0;
      trig_q     <= 1'b0;
      pending    <= '0;
      for (int i = 0; i < int'(REPLICAS); i++) begin
        hoffset[i]  <= '0;
        voffset[i]  <= '0;
        shadow_h[i] <= '0;
        shadow_v[i] <= '0;
        vel_h[i]    <= '0;
        vel_v[i]    <= '0;
      end
    end else begin
      trig_q     <= trig_c;
      frame_done <= 1'b0;
      case (state)
        ACCEPT: begin
          if (wr_valid && wr_ready) begin
            for (int i = 0; i < int'(REPLICAS); i++) begin
              if (32'(wr_idx) == 32'(i)) begin
                if (wr_sel) begin
                  vel_h[i] <= $signed(wr_h[VELW-1:0]);
                  vel_v[i] <= $signed(wr_v[VELW-1:0]);
                end else begin
                  shadow_h[i] <= (32'(wr_h) >= HSIZE) ? HWIDTH'(HSIZE - 1) : wr_h;
                  shadow_v[i] <= (32'(wr_v) >= VSIZE) ? VWIDTH'(VSIZE - 1) : wr_v;
                  pending[i]  <= 1'b1;
                end
              end
            end
          end
          if (rise_c) begin
            state    <= COMMIT;
            cnt      <= '0;
            wr_ready <= 1'b0;
          end
        end
        COMMIT: begin
          for (int i = 0; i < int'(REPLICAS); i++) begin
            if (32'(cnt) == 32'(i)) begin
              if (pending[i]) begin
                hoffset[i] <= shadow_h[i];
                voffset[i] <= shadow_v[i];
                pending[i] <= 1'b0;
              end else begin
                hoffset[i] <= HWIDTH'(wrap($signed(SW'(hoffset[i])) + SW'(vel_h[i]), HSZ));
                voffset[i] <= VWIDTH'(wrap($signed(SW'(voffset[i])) + SW'(vel_v[i]), VSZ));
              end
            end
          end
          if (32'(cnt) == REPLICAS - 1) begin
            state      <= DONE;
            cnt        <= '0;
            frame_done <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          state    <= ACCEPT;
          wr_ready <= 1'b1;
        end
        default: begin
          state    <= ACCEPT;
          wr_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_layer_offset_scheduler.sv
// Directed bench for layer_offset_scheduler (two replicas) with a frame-level reference model
// compared every cycle, plus literal expectations at the key points of each scenario.
module tb_layer_offset_scheduler;

  localparam int R = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] hdata, vdata, wr_h, wr_v;
  logic        wr_valid, wr_sel, wr_ready, frame_done;
  logic [3:0]  wr_idx;
  logic [11:0] hoffset [R];
  logic [11:0] voffset [R];

  int checks = 0;
  int failures = 0;
  bit run = 1'b0;

  always #5 clk = ~clk;

  layer_offset_scheduler #(.REPLICAS(R)) dut (
    .clk(clk), .rst(rst), .hdata(hdata), .vdata(vdata),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_idx(wr_idx), .wr_sel(wr_sel),
    .wr_h(wr_h), .wr_v(wr_v), .hoffset(hoffset), .voffset(voffset),
    .frame_done(frame_done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: counts cycles since the trigger instead of tracking a state machine.
  int  mh[R], mv[R], sh[R], sv[R], vh[R], vv[R];
  bit  pend[R];
  int  since = 0;
  bit  prev_cond = 1'b0;
  bit  cond_m;
  bit  m_ready = 1'b1;
  bit  m_fd = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < R; i++) begin
        mh[i] = 0; mv[i] = 0; sh[i] = 0; sv[i] = 0; vh[i] = 0; vv[i] = 0; pend[i] = 1'b0;
      end
      since = 0;
      prev_cond = 1'b0;
    end else begin
      cond_m = (hdata == 12'd0) && (vdata == 12'd480);
      if (since == 0) begin
        if (wr_valid && int'(wr_idx) < R) begin
          if (wr_sel) begin
            vh[wr_idx] = int'($signed(wr_h[7:0]));
            vv[wr_idx] = int'($signed(wr_v[7:0]));
          end else begin
            sh[wr_idx] = (int'(wr_h) > 639) ? 639 : int'(wr_h);
            sv[wr_idx] = (int'(wr_v) > 479) ? 479 : int'(wr_v);
            pend[wr_idx] = 1'b1;
          end
        end
        if (cond_m && !prev_cond) since = 1;
      end else begin
        if (since <= R) begin
          if (pend[since-1]) begin
            mh[since-1] = sh[since-1];
            mv[since-1] = sv[since-1];
            pend[since-1] = 1'b0;
          end else begin
            mh[since-1] = ((mh[since-1] + vh[since-1]) % 640 + 640) % 640;
            mv[since-1] = ((mv[since-1] + vv[since-1]) % 480 + 480) % 480;
          end
        end
        since = (since == R + 1) ? 0 : since + 1;
      end
      prev_cond = cond_m;
    end
    m_ready = (since == 0);
    m_fd = (since == R + 1);
  end

  always @(negedge clk) begin
    if (run) begin
      for (int i = 0; i < R; i++) begin
        chk($sformatf("model_hoffset%0d", i), 32'(hoffset[i]), mh[i]);
        chk($sformatf("model_voffset%0d", i), 32'(voffset[i]), mv[i]);
      end
      chk("model_wr_ready", 32'(wr_ready), 32'(m_ready));
      chk("model_frame_done", 32'(frame_done), 32'(m_fd));
    end
  end

  task automatic wr(input int idx, input bit sel, input int h, input int v);
    wr_valid = 1'b1; wr_idx = 4'(idx); wr_sel = sel; wr_h = 12'(h); wr_v = 12'(v);
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic frame();
    hdata = 12'd0; vdata = 12'd480;
    @(negedge clk);
    hdata = 12'd5; vdata = 12'd100;
    repeat (5) @(negedge clk);
  endtask

  task automatic chk_rep(input string tag, input int idx, input int h, input int v);
    chk({tag, "_h"}, 32'(hoffset[idx]), h);
    chk({tag, "_v"}, 32'(voffset[idx]), v);
  endtask

  int fd_cnt;

  initial begin
    rst = 1'b1; hdata = 12'd5; vdata = 12'd100;
    wr_valid = 1'b0; wr_idx = '0; wr_sel = 1'b0; wr_h = '0; wr_v = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_rep("reset_r0", 0, 0, 0);
    chk_rep("reset_r1", 1, 0, 0);
    chk("reset_ready", 32'(wr_ready), 1);
    chk("reset_fd", 32'(frame_done), 0);
    run = 1'b1;

    // Position write to replica 1, then a commit with exact timing.
    wr(1, 1'b0, 100, 50);
    hdata = 12'd0; vdata = 12'd480;
    @(negedge clk);
    hdata = 12'd5; vdata = 12'd100;
    chk("t1_ready", 32'(wr_ready), 0);
    chk("t1_h1", 32'(hoffset[1]), 0);
    @(negedge clk);
    chk("t2_h1", 32'(hoffset[1]), 0);
    chk("t2_fd", 32'(frame_done), 0);
    @(negedge clk);
    chk_rep("t3_r1", 1, 100, 50);
    chk_rep("t3_r0", 0, 0, 0);
    chk("t3_fd", 32'(frame_done), 1);
    @(negedge clk);
    chk("t4_fd", 32'(frame_done), 0);
    chk("t4_ready", 32'(wr_ready), 1);
    wr(1, 1'b0, 200, 60);
    repeat (3) @(negedge clk);
    chk_rep("no_trig_r1", 1, 100, 50);

    // Velocity scroll with negative wrap.
    wr(0, 1'b1, 5, -3);
    frame();
    chk_rep("vel_f1_r0", 0, 5, 477);
    chk_rep("vel_f1_r1", 1, 200, 60);
    frame();
    chk_rep("vel_f2_r0", 0, 10, 474);

    // Positive wrap from 638.
    wr(0, 1'b0, 638, 0);
    frame();
    chk_rep("pos638_r0", 0, 638, 0);
    frame();
    chk_rep("wrap_r0", 0, 3, 477);

    // Held trigger level and a write stalled through the blackout.
    hdata = 12'd0; vdata = 12'd480;
    @(negedge clk);
    wr_valid = 1'b1; wr_idx = 4'd1; wr_sel = 1'b0; wr_h = 12'd300; wr_v = 12'd30;
    fd_cnt = 0;
    for (int k = 1; k <= 8; k++) begin
      if (k <= 3) chk($sformatf("hold_ready_t%0d", k), 32'(wr_ready), 0);
      if (k == 4) begin
        chk("hold_ready_t4", 32'(wr_ready), 1);
        hdata = 12'd5; vdata = 12'd100;
      end
      if (k == 5) wr_valid = 1'b0;
      fd_cnt += int'(frame_done);
      @(negedge clk);
    end
    chk("hold_fd_count", fd_cnt, 1);
    chk_rep("hold_r0", 0, 8, 474);
    chk_rep("hold_r1_before", 1, 200, 60);
    frame();
    chk_rep("stalled_wr_r1", 1, 300, 30);
    chk_rep("stalled_wr_r0", 0, 13, 471);

    // Saturation and out-of-range index.
    wr(1, 1'b0, 700, 500);
    frame();
    chk_rep("sat_r1", 1, 639, 479);
    chk_rep("sat_r0", 0, 18, 468);
    wr(3, 1'b0, 9, 9);
    chk("bad_idx_ready", 32'(wr_ready), 1);
    frame();
    chk_rep("bad_idx_r1", 1, 639, 479);
    chk_rep("bad_idx_r0", 0, 23, 465);

    // Write accepted in the trigger cycle joins that commit.
    hdata = 12'd0; vdata = 12'd480;
    wr_valid = 1'b1; wr_idx = 4'd0; wr_sel = 1'b0; wr_h = 12'd7; wr_v = 12'd8;
    @(negedge clk);
    hdata = 12'd5; vdata = 12'd100; wr_valid = 1'b0;
    @(negedge clk);
    chk_rep("same_cycle_r0", 0, 7, 8);
    repeat (4) @(negedge clk);
    frame();
    chk_rep("after_pending_r0", 0, 12, 5);

    // Reset in the middle of a commit.
    hdata = 12'd0; vdata = 12'd480;
    @(negedge clk);
    hdata = 12'd5; vdata = 12'd100; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_rep("midrst_r0", 0, 0, 0);
    chk_rep("midrst_r1", 1, 0, 0);
    chk("midrst_ready", 32'(wr_ready), 1);
    chk("midrst_fd", 32'(frame_done), 0);
    frame();
    chk_rep("postrst_r0", 0, 0, 0);
    chk_rep("postrst_r1", 1, 0, 0);

    run = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
